// File: rtl/quota_pkg.sv
// Shared definitions for the stochastic bitstream generator.
// Holds the FSM state type, the stream-mode encodings and two helper
// functions used both to size ports and to build the spread-mode ordering.
package quota_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam logic MODE_THERM  = 1'b0;
    localparam logic MODE_SPREAD = 1'b1;

    // A quota spans 0..BITSTREAM inclusive, so it needs one bit more than
    // the beat counter.
    function automatic int quota_width(input int bitstream);
        return $clog2(bitstream) + 1;
    endfunction

    // Reverses the low 'width' bits of value; upper bits of the result are zero.
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < width; i++) begin
            r = r | (((value >> i) & 32'd1) << (width - 1 - i));
        end
        return r;
    endfunction

endpackage

// File: rtl/quota_calc.sv
// Combinational per-channel converter from a signed QUANT-bit sample to
// the number of ones its BITSTREAM-beat window must contain.
// Ports:
//   data  - signed two's complement sample
//   quota - rounded ones-count, 0..BITSTREAM
module quota_calc
    import quota_pkg::*;
#(
    parameter int QUANT     = 8,
    parameter int BITSTREAM = 64,
    localparam int CW       = $clog2(BITSTREAM),
    localparam int QW       = quota_width(BITSTREAM),
    localparam int SH       = QUANT - CW
) (
    input  logic [QUANT-1:0] data,
    output logic [QW-1:0]    quota
);

    localparam int HALF_LSB = 2 ** (SH - 1);

    logic [QUANT:0] biased;
    logic [QUANT:0] rounded;
    logic [QUANT:0] half_lsb;

    // Adding 2^(QUANT-1) to a two's complement value is the same as
    // flipping its sign bit; the extra top bit leaves headroom for rounding.
    // The maximum rounded value shifted down is exactly BITSTREAM, so no
    // saturation is needed.
    assign half_lsb = HALF_LSB[QUANT:0];
    assign biased   = {1'b0, ~data[QUANT-1], data[QUANT-2:0]};
    assign rounded  = biased + half_lsb;
    assign quota    = QW'(rounded >> SH);

endmodule

// File: rtl/quota_stream_gen.sv
// Multi-channel stochastic bitstream generator.
// Accepts a vector of CHANNELS signed samples, converts each to a quota and
// emits BITSTREAM beats per channel holding exactly that many ones, either
// packed at the start (thermometer) or evenly spread (bit-reversed counter).
// Ports:
//   clk, rst_n           - clock and asynchronous active-low reset
//   in_valid/in_ready    - input vector handshake
//   in_data              - packed samples, channel c at [c*QUANT +: QUANT]
//   in_mode              - 0 thermometer, 1 spread; sampled on accept
//   bs_valid/bs_ready    - output beat handshake
//   bs_bits              - one stream bit per channel
//   bs_first, bs_last    - beat 0 / beat BITSTREAM-1 markers
//   quota_o              - latched quotas, QW bits per channel
module quota_stream_gen
    import quota_pkg::*;
#(
    parameter int BITSTREAM = 64,
    parameter int QUANT     = 8,
    parameter int CHANNELS  = 4,
    localparam int QW       = quota_width(BITSTREAM)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*QUANT-1:0] in_data,
    input  logic                      in_mode,
    output logic                      bs_valid,
    input  logic                      bs_ready,
    output logic [CHANNELS-1:0]       bs_bits,
    output logic                      bs_first,
    output logic                      bs_last,
    output logic [CHANNELS*QW-1:0]    quota_o
);

    localparam int CW = $clog2(BITSTREAM);

    if (BITSTREAM < 2 || (BITSTREAM & (BITSTREAM - 1)) != 0) begin : g_bad_bitstream
        $error("quota_stream_gen: BITSTREAM must be a power of two");
    end
    if (QUANT <= CW) begin : g_bad_quant
        $error("quota_stream_gen: QUANT must exceed clog2(BITSTREAM)");
    end
    if (CHANNELS < 1) begin : g_bad_channels
        $error("quota_stream_gen: CHANNELS must be at least 1");
    end

    state_t                  state;
    state_t                  state_next;
    logic [CW-1:0]           cnt;
    logic [CHANNELS*QW-1:0]  quota_q;
    logic                    mode_q;
    logic [CHANNELS*QW-1:0]  quota_new;
    logic                    cnt_last;
    logic                    accept;
    logic                    beat_done;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_calc
        quota_calc #(
            .QUANT     (QUANT),
            .BITSTREAM (BITSTREAM)
        ) u_calc (
            .data  (in_data[c*QUANT +: QUANT]),
            .quota (quota_new[c*QW +: QW])
        );
    end

    assign cnt_last  = (cnt == CW'(BITSTREAM - 1));
    assign accept    = in_valid & in_ready;
    assign beat_done = bs_valid & bs_ready;

    // State register; reset mid-window simply abandons the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake outputs. in_ready opens on the last beat only
    // when that beat is being taken, so a new vector can follow with no bubble.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        bs_valid   = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                bs_valid = 1'b1;
                in_ready = cnt_last & bs_ready;
                if (cnt_last && bs_ready && !in_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Beat counter plus the quotas and mode captured on accept. After the
    // final beat without a new vector the counter wraps to zero on its own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            quota_q <= '0;
            mode_q  <= MODE_THERM;
        end else if (accept) begin
            cnt     <= '0;
            quota_q <= quota_new;
            mode_q  <= in_mode;
        end else if (beat_done) begin
            cnt     <= cnt + 1'b1;
        end
    end

    // Stream bits come from registered state only. Spread mode compares the
    // bit-reversed counter against the quota; since reversal is a permutation
    // of the beat indices the ones count is unchanged but evenly distributed.
    always_comb begin
        logic [CW-1:0] idx;
        logic [QW-1:0] q;
        bs_bits = '0;
        idx     = (mode_q == MODE_SPREAD) ? CW'(bitrev(32'(cnt), CW)) : cnt;
        q       = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            q          = quota_q[c*QW +: QW];
            bs_bits[c] = bs_valid & ({1'b0, idx} < q);
        end
    end

    assign bs_first = bs_valid & (cnt == '0);
    assign bs_last  = bs_valid & cnt_last;
    assign quota_o  = quota_q;

endmodule
